// File: rtl/seq_detect_ctrl_pkg.sv
// seq_detect_pkg: FSM state type, config reset defaults and length saturation helper.
package seq_detect_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic DEF_OVERLAP = 1'b1;
  localparam int DEF_PATTERN = 0;
  localparam int DEF_LIMIT = 0;
  function automatic int sat_len(int len, int max_len);
    return len < 1 ? 1 : (len > max_len ? max_len : len);
  endfunction
endpackage

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: config, control, serial bit and result signals of the detector.
interface seq_detect_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_limit;
  logic               start;
  logic               abort;
  logic               bit_valid;
  logic               new_bit;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;
  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, start, abort, bit_valid, new_bit,
    input  cfg_ready, detected, match_count, busy, done
  );
  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit, start, abort, bit_valid, new_bit,
    output cfg_ready, detected, match_count, busy, done
  );
endinterface

// File: rtl/seq_detect_ctrl_core.sv
// seq_match_core: shift register, fill counter and masked pattern compare on next-state values.
module seq_match_core #(
  parameter int MAX_LEN = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               shift_en_i,
  input  logic               bit_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic               overlap_i,
  output logic               match_o
);
  logic [MAX_LEN-1:0] shift_q, shift_d, mask;
  logic [LEN_W-1:0]   fill_q, fill_d;
  always_comb begin
    shift_d = shift_en_i ? {shift_q[MAX_LEN-2:0], bit_i} : shift_q;
    fill_d = shift_en_i && fill_q != LEN_W'(MAX_LEN) ? fill_q + 1'b1 : fill_q;
    mask = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_i);
    match_o = shift_en_i && fill_d >= len_i && ((shift_d ^ pattern_i) & mask) == '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      shift_q <= '0;
      fill_q <= '0;
    end else begin
      shift_q <= shift_d;
      fill_q <= match_o && !overlap_i ? '0 : fill_d;
    end
  end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial sequence detector with start/abort run control and match counting.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input logic clk,
  input logic rst_n,
  seq_detect_ctrl_if.slave bus
);
  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q, det_q;
  logic [CNT_W-1:0]   limit_q, cnt_q, cnt_d, cnt_inc;
  logic               cfg_take, run_go, shift_en, match, hit_limit;
  assign cfg_take = bus.cfg_valid && state_q != RUN;
  assign run_go = state_q != RUN && bus.start && !bus.abort;
  assign shift_en = state_q == RUN && bus.bit_valid && !bus.abort;
  seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (run_go),
    .shift_en_i (shift_en),
    .bit_i      (bus.new_bit),
    .len_i      (len_q),
    .pattern_i  (pattern_q),
    .overlap_i  (overlap_q),
    .match_o    (match)
  );
  always_comb begin
    cnt_inc = cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
    hit_limit = match && limit_q != '0 && cnt_inc == limit_q;
    state_d = bus.abort ? IDLE
            : run_go ? RUN
            : state_q == RUN ? (hit_limit ? DONE : RUN)
            : cfg_take ? IDLE : state_q;
    cnt_d = run_go ? '0 : match ? cnt_inc : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      det_q <= 1'b0;
      pattern_q <= MAX_LEN'(DEF_PATTERN);
      len_q <= LEN_W'(MAX_LEN);
      overlap_q <= DEF_OVERLAP;
      limit_q <= CNT_W'(DEF_LIMIT);
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      det_q <= match;
      if (cfg_take) begin
        pattern_q <= bus.cfg_pattern;
        len_q <= LEN_W'(sat_len(int'(bus.cfg_len), MAX_LEN));
        overlap_q <= bus.cfg_overlap;
        limit_q <= bus.cfg_limit;
      end
    end
  end
  assign bus.cfg_ready = state_q != RUN;
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.detected = det_q;
  assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed and randomized checks of seq_detect_ctrl against a bit-history reference model.
module tb_seq_detect_ctrl;
  logic clk, rst_n;
  seq_detect_ctrl_if bus ();
  seq_detect_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_ok, n_chk;
  logic [7:0] m_pat;
  int m_len, m_lim, m_cnt, m_st;
  logic m_ovl, m_det;
  logic hist[$];

  task automatic model_reset();
    m_pat = 8'h00; m_len = 8; m_ovl = 1'b1; m_lim = 0;
    m_cnt = 0; m_st = 0; m_det = 1'b0;
    hist.delete();
  endtask

  // m_st: 0 idle, 1 running, 2 limit reached
  task automatic model(logic cv, logic st, logic ab, logic v, logic b);
    logic ok;
    m_det = 1'b0;
    if (m_st == 1) begin
      if (ab) m_st = 0;
      else if (v) begin
        hist.push_back(b);
        if (hist.size() > 16) void'(hist.pop_front());
        if (hist.size() >= m_len) begin
          ok = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (hist[hist.size() - 1 - i] != m_pat[i]) ok = 1'b0;
          if (ok) begin
            m_det = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) hist.delete();
            if (m_lim != 0 && m_cnt == m_lim) m_st = 2;
          end
        end
      end
    end else begin
      if (cv) begin
        m_pat = bus.cfg_pattern;
        m_len = bus.cfg_len == 0 ? 1 : (bus.cfg_len > 8 ? 8 : int'(bus.cfg_len));
        m_ovl = bus.cfg_overlap;
        m_lim = int'(bus.cfg_limit);
        if (m_st == 2) m_st = 0;
      end
      if (ab) m_st = 0;
      else if (st) begin
        m_st = 1; m_cnt = 0; hist.delete();
      end
    end
  endtask

  task automatic drive(logic cv, logic st, logic ab, logic v, logic b);
    bus.cfg_valid = cv; bus.start = st; bus.abort = ab; bus.bit_valid = v; bus.new_bit = b;
    model(cv, st, ab, v, b);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.bit_valid = 1'b0;
  endtask

  task automatic cfg(logic [7:0] p, logic [3:0] l, logic o, logic [7:0] lim);
    bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_overlap = o; bus.cfg_limit = lim;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_ok++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_ok++;
    n_chk++; if (bus.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready); else n_ok++;
    n_chk++; if (bus.detected !== 1'b0) $display("FAIL reset_detected: got %b want 0", bus.detected); else n_ok++;
    n_chk++; if (bus.match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.match_count); else n_ok++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_chk++; if (bus.detected !== m_det) $display("FAIL default_cfg_det bit %0d: got %b want %b", i + 1, bus.detected, m_det); else n_ok++;
    end
    n_chk++; if (bus.match_count !== 8'd1) $display("FAIL default_cfg_count: got %0d want 1", bus.match_count); else n_ok++;
  endtask

  task automatic test_overlap(logic ovl);
    logic [9:0] s;
    s = 10'b1100110011;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'b00110011, 4'd6, ovl, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, s[9-i]);
      n_chk++; if (bus.detected !== m_det) $display("FAIL ovl%0d_det bit %0d: got %b want %b", ovl, i + 1, bus.detected, m_det); else n_ok++;
    end
    n_chk++; if (bus.match_count !== (ovl ? 8'd2 : 8'd1)) $display("FAIL ovl%0d_count: got %0d want %0d", ovl, bus.match_count, ovl ? 2 : 1); else n_ok++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL ovl%0d_done: got %b want 0", ovl, bus.done); else n_ok++;
  endtask

  task automatic test_limit();
    logic [7:0] s;
    s = 8'b10101010;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'b1010, 4'd4, 1'b1, 8'd2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, s[7-i]);
      n_chk++; if (bus.detected !== m_det) $display("FAIL limit_det bit %0d: got %b want %b", i + 1, bus.detected, m_det); else n_ok++;
    end
    n_chk++; if (bus.match_count !== 8'd2) $display("FAIL limit_count: got %0d want 2", bus.match_count); else n_ok++;
    n_chk++; if (bus.done !== 1'b1) $display("FAIL limit_done: got %b want 1", bus.done); else n_ok++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL limit_busy: got %b want 0", bus.busy); else n_ok++;
    n_chk++; if (bus.cfg_ready !== 1'b1) $display("FAIL limit_cfg_ready: got %b want 1", bus.cfg_ready); else n_ok++;
  endtask

  task automatic test_sparse();
    logic [7:0] s;
    s = 8'b10101010;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'b1010, 4'd4, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, ~s[7-i]);
      n_chk++; if (bus.detected !== 1'b0) $display("FAIL sparse_idle_det cycle %0d: got %b want 0", i, bus.detected); else n_ok++;
      drive(1'b0, 1'b0, 1'b0, 1'b1, s[7-i]);
      n_chk++; if (bus.detected !== m_det) $display("FAIL sparse_det bit %0d: got %b want %b", i + 1, bus.detected, m_det); else n_ok++;
    end
    n_chk++; if (bus.match_count !== 8'd3) $display("FAIL sparse_count: got %0d want 3", bus.match_count); else n_ok++;
  endtask

  task automatic test_cfg();
    logic [15:0] s;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'b1010, 4'd4, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.cfg_pattern = 8'h0F; bus.cfg_len = 4'd4;
    n_chk++; if (bus.cfg_ready !== 1'b0) $display("FAIL run_cfg_ready: got %b want 0", bus.cfg_ready); else n_ok++;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    s = 16'b1010;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, s[3-i]);
      n_chk++; if (bus.detected !== m_det) $display("FAIL run_cfg_ignored bit %0d: got %b want %b", i + 1, bus.detected, m_det); else n_ok++;
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'h01, 4'd0, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    s = 16'b1011;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, s[3-i]);
      n_chk++; if (bus.detected !== s[3-i]) $display("FAIL len0_det bit %0d: got %b want %b", i + 1, bus.detected, s[3-i]); else n_ok++;
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'hA5, 4'd15, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    s = 16'h25A5;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, s[15-i]);
      n_chk++; if (bus.detected !== m_det) $display("FAIL len15_det bit %0d: got %b want %b", i + 1, bus.detected, m_det); else n_ok++;
    end
    n_chk++; if (bus.match_count !== 8'd1) $display("FAIL len15_count: got %0d want 1", bus.match_count); else n_ok++;
  endtask

  task automatic test_start_abort();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL start_abort_busy: got %b want 0", bus.busy); else n_ok++;
    n_chk++; if (bus.match_count !== 8'(m_cnt)) $display("FAIL start_abort_count: got %0d want %0d", bus.match_count, m_cnt); else n_ok++;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_chk++; if (bus.detected !== 1'b0) $display("FAIL idle_bit_det: got %b want 0", bus.detected); else n_ok++;
  endtask

  task automatic test_reset_midrun();
    logic [5:0] s;
    s = 6'b110011;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'b00110011, 4'd6, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, s[5-i]);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, s[0]);
    rst_n = 1'b1;
    model_reset();
    n_chk++; if (bus.detected !== 1'b0) $display("FAIL rst_mid_det: got %b want 0", bus.detected); else n_ok++;
    n_chk++; if (bus.match_count !== 8'd0) $display("FAIL rst_mid_count: got %0d want 0", bus.match_count); else n_ok++;
    n_chk++; if (bus.cfg_ready !== 1'b1) $display("FAIL rst_mid_cfg_ready: got %b want 1", bus.cfg_ready); else n_ok++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.busy); else n_ok++;
  endtask

  task automatic test_saturate();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cfg(8'h01, 4'd1, 1'b1, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_chk++; if (bus.match_count !== 8'd255) $display("FAIL saturate_count: got %0d want 255", bus.match_count); else n_ok++;
    n_chk++; if (bus.detected !== m_det) $display("FAIL saturate_det: got %b want %b", bus.detected, m_det); else n_ok++;
  endtask

  task automatic test_random();
    logic v, b;
    for (int r = 0; r < 10; r++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cfg(8'($urandom), 4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) begin
        v = $urandom_range(0, 3) != 0;
        b = 1'($urandom_range(0, 1));
        drive(1'b0, 1'b0, 1'b0, v, b);
        n_chk++; if (bus.detected !== m_det) $display("FAIL rand_det run %0d cyc %0d: got %b want %b", r, i, bus.detected, m_det); else n_ok++;
        n_chk++; if (bus.match_count !== 8'(m_cnt)) $display("FAIL rand_count run %0d cyc %0d: got %0d want %0d", r, i, bus.match_count, m_cnt); else n_ok++;
        n_chk++; if (bus.busy !== (m_st == 1)) $display("FAIL rand_busy run %0d cyc %0d: got %b want %b", r, i, bus.busy, m_st == 1); else n_ok++;
        n_chk++; if (bus.done !== (m_st == 2)) $display("FAIL rand_done run %0d cyc %0d: got %b want %b", r, i, bus.done, m_st == 2); else n_ok++;
      end
    end
  endtask

  initial begin
    n_ok = 0; n_chk = 0;
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.bit_valid = 1'b0; bus.new_bit = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b1; bus.cfg_limit = '0;
    model_reset();
    test_reset();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_limit();
    test_sparse();
    test_cfg();
    test_start_abort();
    test_reset_midrun();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
